change_dispenser: RTL

//   Coin-output side of the drink vending machine: the FSM that accepts coins hands this block a change amount.

---
 rtl/change_dispenser.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a change amount into 50/10/5/1 coins (greedy,
// largest first), hands them to the hopper one at a time over a valid/ack
// handshake, keeps per-denomination inventory and reports any unpaid rest.
module change_dispenser #(
  parameter int AMT_W   = 8,
  parameter int CNT_W   = 6,
  parameter int INIT_50 = 4,
  parameter int INIT_10 = 10,
  parameter int INIT_5  = 10,
  parameter int INIT_1  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             coin_valid,
  output logic [AMT_W-1:0] coin_value,
  input  logic             coin_ack,
  input  logic             refill,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] short_amount,
  output logic [3:0]       empty
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] COIN_50  = AMT_W'(32'd50);
  localparam logic [AMT_W-1:0] COIN_10  = AMT_W'(32'd10);
  localparam logic [AMT_W-1:0] COIN_5   = AMT_W'(32'd5);
  localparam logic [AMT_W-1:0] COIN_1   = AMT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] LOAD_50  = CNT_W'(INIT_50);
  localparam logic [CNT_W-1:0] LOAD_10  = CNT_W'(INIT_10);
  localparam logic [CNT_W-1:0] LOAD_5   = CNT_W'(INIT_5);
  localparam logic [CNT_W-1:0] LOAD_1   = CNT_W'(INIT_1);

  state_t           state_r, state_s;
  logic [AMT_W-1:0] rem_r, rem_s;
  logic [CNT_W-1:0] cnt50_r, cnt10_r, cnt5_r, cnt1_r;
  logic [CNT_W-1:0] cnt50_s, cnt10_s, cnt5_s, cnt1_s;
  logic             req_ready_s, coin_valid_s, done_s, short_s;
  logic [AMT_W-1:0] coin_value_s, short_amount_s, pick_s;

  // Greedy choice: largest denomination that fits the remainder and is in stock.
  // Returns zero when nothing qualifies.
  function automatic logic [AMT_W-1:0] pick_coin(
    input logic [AMT_W-1:0] amt,
    input logic [CNT_W-1:0] c50,
    input logic [CNT_W-1:0] c10,
    input logic [CNT_W-1:0] c5,
    input logic [CNT_W-1:0] c1
  );
    logic [AMT_W-1:0] d;
    if (amt >= COIN_50 && c50 != CNT_ZERO) begin
      d = COIN_50;
    end else if (amt >= COIN_10 && c10 != CNT_ZERO) begin
      d = COIN_10;
    end else if (amt >= COIN_5 && c5 != CNT_ZERO) begin
      d = COIN_5;
    end else if (amt >= COIN_1 && c1 != CNT_ZERO) begin
      d = COIN_1;
    end else begin
      d = AMT_ZERO;
    end
    return d;
  endfunction

  // Next-state, datapath and next-output computation for the dispenser FSM.
  always_comb begin
    state_s        = state_r;
    rem_s          = rem_r;
    cnt50_s        = cnt50_r;
    cnt10_s        = cnt10_r;
    cnt5_s         = cnt5_r;
    cnt1_s         = cnt1_r;
    req_ready_s    = req_ready;
    coin_valid_s   = coin_valid;
    coin_value_s   = coin_value;
    done_s         = 1'b0;
    short_s        = short;
    short_amount_s = short_amount;
    pick_s         = pick_coin(rem_r, cnt50_r, cnt10_r, cnt5_r, cnt1_r);

    case (state_r)
      IDLE: begin
        req_ready_s = 1'b1;
        if (req_valid && req_ready) begin
          rem_s       = req_amount;
          req_ready_s = 1'b0;
          state_s     = SELECT;
        end else if (refill) begin
          cnt50_s = LOAD_50;
          cnt10_s = LOAD_10;
          cnt5_s  = LOAD_5;
          cnt1_s  = LOAD_1;
        end else begin
          state_s = IDLE;
        end
      end

      SELECT: begin
        req_ready_s = 1'b0;
        if (rem_r == AMT_ZERO) begin
          done_s         = 1'b1;
          short_s        = 1'b0;
          short_amount_s = AMT_ZERO;
          state_s        = DONE;
        end else if (pick_s != AMT_ZERO) begin
          coin_value_s = pick_s;
          coin_valid_s = 1'b1;
          state_s      = EMIT;
        end else begin
          // Nothing in stock fits: give up and report what is left unpaid.
          done_s         = 1'b1;
          short_s        = 1'b1;
          short_amount_s = rem_r;
          state_s        = DONE;
        end
      end

      EMIT: begin
        req_ready_s = 1'b0;
        if (coin_ack) begin
          rem_s        = rem_r - coin_value;
          coin_valid_s = 1'b0;
          state_s      = SELECT;
          case (coin_value)
            COIN_50: cnt50_s = cnt50_r - CNT_ONE;
            COIN_10: cnt10_s = cnt10_r - CNT_ONE;
            COIN_5:  cnt5_s  = cnt5_r - CNT_ONE;
            COIN_1:  cnt1_s  = cnt1_r - CNT_ONE;
            default: cnt1_s  = cnt1_r;
          endcase
        end else begin
          coin_valid_s = 1'b1;
        end
      end

      DONE: begin
        req_ready_s = 1'b1;
        state_s     = IDLE;
      end

      default: begin
        req_ready_s  = 1'b1;
        coin_valid_s = 1'b0;
        state_s      = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset reloads inventory and drops any coin in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      rem_r        <= AMT_ZERO;
      cnt50_r      <= LOAD_50;
      cnt10_r      <= LOAD_10;
      cnt5_r       <= LOAD_5;
      cnt1_r       <= LOAD_1;
      req_ready    <= 1'b1;
      coin_valid   <= 1'b0;
      coin_value   <= AMT_ZERO;
      done         <= 1'b0;
      short        <= 1'b0;
      short_amount <= AMT_ZERO;
      empty        <= {LOAD_50 == CNT_ZERO, LOAD_10 == CNT_ZERO,
                       LOAD_5 == CNT_ZERO, LOAD_1 == CNT_ZERO};
    end else begin
      state_r      <= state_s;
      rem_r        <= rem_s;
      cnt50_r      <= cnt50_s;
      cnt10_r      <= cnt10_s;
      cnt5_r       <= cnt5_s;
      cnt1_r       <= cnt1_s;
      req_ready    <= req_ready_s;
      coin_valid   <= coin_valid_s;
      coin_value   <= coin_value_s;
      done         <= done_s;
      short        <= short_s;
      short_amount <= short_amount_s;
      // Empty flags follow the counters one cycle later.
      empty        <= {cnt50_r == CNT_ZERO, cnt10_r == CNT_ZERO,
                       cnt5_r == CNT_ZERO, cnt1_r == CNT_ZERO};
    end
  end

endmodule
